// File: rtl/memory_arbiter_if.sv
// Bundle of the instruction-side, data-side and shared-memory signals of memory_arbiter.
// Latency: none (wires only).
// Backpressure: carries i_mem_ready/d_mem_ready toward requesters and mem_ready from memory.
interface memory_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
);
  // instruction-side request / response
  logic                    i_mem_read;
  logic [ADDRESS_BITS-1:0] i_mem_address_in;
  logic [DATA_WIDTH-1:0]   i_mem_data_out;
  logic [ADDRESS_BITS-1:0] i_mem_address_out;
  logic                    i_mem_valid;
  logic                    i_mem_ready;

  // data-side request / response
  logic                    d_mem_read;
  logic                    d_mem_write;
  logic [DATA_WIDTH/8-1:0] d_mem_byte_en;
  logic [ADDRESS_BITS-1:0] d_mem_address_in;
  logic [DATA_WIDTH-1:0]   d_mem_data_in;
  logic [DATA_WIDTH-1:0]   d_mem_data_out;
  logic [ADDRESS_BITS-1:0] d_mem_address_out;
  logic                    d_mem_valid;
  logic                    d_mem_ready;

  // shared memory command / response
  logic                    mem_read;
  logic                    mem_write;
  logic [DATA_WIDTH/8-1:0] mem_byte_en;
  logic [ADDRESS_BITS-1:0] mem_address_in;
  logic [DATA_WIDTH-1:0]   mem_data_in;
  logic [DATA_WIDTH-1:0]   mem_data_out;
  logic [ADDRESS_BITS-1:0] mem_address_out;
  logic                    mem_valid;
  logic                    mem_ready;

  // arbiter side
  modport slave (
    input  i_mem_read, i_mem_address_in,
    output i_mem_data_out, i_mem_address_out, i_mem_valid, i_mem_ready,
    input  d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in,
    output d_mem_data_out, d_mem_address_out, d_mem_valid, d_mem_ready,
    output mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    input  mem_data_out, mem_address_out, mem_valid, mem_ready
  );

  // environment side: requesters plus memory
  modport master (
    output i_mem_read, i_mem_address_in,
    input  i_mem_data_out, i_mem_address_out, i_mem_valid, i_mem_ready,
    output d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in,
    input  d_mem_data_out, d_mem_address_out, d_mem_valid, d_mem_ready,
    input  mem_read, mem_write, mem_byte_en, mem_address_in, mem_data_in,
    output mem_data_out, mem_address_out, mem_valid, mem_ready
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requesters onto one shared memory port, one transaction at a time.
// Latency: grant edge -> 1-cycle mem_read/mem_write pulse; response forwarded combinationally on mem_valid.
// Backpressure: requesters accepted only in IDLE with mem_ready=1; no timeout waiting for mem_valid.
// Build option: define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin on contention (default: data side wins).
module memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
) (
  input logic              clock,
  input logic              reset,
  input logic              scan,
  memory_arbiter_if.slave  bus
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // pending requests and arbitration result
  logic i_pend;
  logic d_pend;
  logic d_wins;
  logic grant_i;
  logic grant_d;

  // last winner: 0 = instruction side, 1 = data side
  logic last_grant_q;

  // latched memory command
  logic                    cmd_read_q;
  logic                    cmd_write_q;
  logic [BE_W-1:0]         cmd_byte_en_q;
  logic [ADDRESS_BITS-1:0] cmd_address_q;
  logic [DATA_WIDTH-1:0]   cmd_data_q;

  // combinational requester-facing outputs
  logic                    i_ready;
  logic                    d_ready;
  logic                    i_valid;
  logic                    d_valid;
  logic [DATA_WIDTH-1:0]   i_data;
  logic [DATA_WIDTH-1:0]   d_data;
  logic [ADDRESS_BITS-1:0] i_address;
  logic [ADDRESS_BITS-1:0] d_address;

  // scan only steers simulation-side tracing; the datapath never looks at it
  logic unused_scan;
  assign unused_scan = scan;

  assign i_pend = bus.i_mem_read;
  assign d_pend = bus.d_mem_read | bus.d_mem_write;

  // contention rule: who wins when both sides are pending
  always_comb begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    d_wins = ~last_grant_q;
`else
    d_wins = 1'b1;
`endif
  end

  // next state, grants, accept strobes and response steering
  always_comb begin
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    i_data    = '0;
    d_data    = '0;
    i_address = '0;
    d_address = '0;
    case (state_q)
      IDLE: begin
        // mem_valid is deliberately ignored here: nobody owns the port
        if (bus.mem_ready) begin
          grant_i = i_pend & ~(d_pend & d_wins);
          grant_d = d_pend & ~(i_pend & ~d_wins);
          i_ready = grant_i | ~(i_pend | d_pend);
          d_ready = grant_d | ~(i_pend | d_pend);
          if (grant_i) begin
            state_d = I_WAIT;
          end else if (grant_d) begin
            state_d = D_WAIT;
          end
        end
      end
      I_WAIT: begin
        if (bus.mem_valid) begin
          i_valid   = 1'b1;
          i_data    = bus.mem_data_out;
          i_address = bus.mem_address_out;
          state_d   = IDLE;
        end
      end
      D_WAIT: begin
        if (bus.mem_valid) begin
          d_valid   = 1'b1;
          d_data    = bus.mem_data_out;
          d_address = bus.mem_address_out;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; reset drops any in-flight transaction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // remember the last winner so round-robin can alternate on contention
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
    end else if (grant_i) begin
      last_grant_q <= 1'b0;
    end else if (grant_d) begin
      last_grant_q <= 1'b1;
    end
  end

  // latch the winner's command; read/write strobes live for exactly one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_read_q    <= 1'b0;
      cmd_write_q   <= 1'b0;
      cmd_byte_en_q <= '0;
      cmd_address_q <= '0;
      cmd_data_q    <= '0;
    end else begin
      cmd_read_q  <= 1'b0;
      cmd_write_q <= 1'b0;
      if (grant_i) begin
        cmd_read_q    <= 1'b1;
        cmd_byte_en_q <= '1;
        cmd_address_q <= bus.i_mem_address_in;
        cmd_data_q    <= '0;
      end else if (grant_d) begin
        // simultaneous read+write from the data side is issued as a write only
        cmd_read_q    <= bus.d_mem_read & ~bus.d_mem_write;
        cmd_write_q   <= bus.d_mem_write;
        cmd_byte_en_q <= bus.d_mem_byte_en;
        cmd_address_q <= bus.d_mem_address_in;
        cmd_data_q    <= bus.d_mem_data_in;
      end
    end
  end

  assign bus.mem_read          = cmd_read_q;
  assign bus.mem_write         = cmd_write_q;
  assign bus.mem_byte_en       = cmd_byte_en_q;
  assign bus.mem_address_in    = cmd_address_q;
  assign bus.mem_data_in       = cmd_data_q;

  assign bus.i_mem_ready       = i_ready;
  assign bus.i_mem_valid       = i_valid;
  assign bus.i_mem_data_out    = i_data;
  assign bus.i_mem_address_out = i_address;

  assign bus.d_mem_ready       = d_ready;
  assign bus.d_mem_valid       = d_valid;
  assign bus.d_mem_data_out    = d_data;
  assign bus.d_mem_address_out = d_address;

endmodule
